// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with stall/flush handling, multi-cycle accumulator feedback
// and a saturating bubble counter for performance monitoring.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       WE_W        = 3,
  parameter int unsigned       ACC_W       = 64,
  parameter int unsigned       CNT_W       = 2,
  parameter int unsigned       STALL_W     = 6,
  parameter int unsigned       STAGE_IDX   = 3,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0,
  parameter int unsigned       PERF_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WE_W-1:0]    in_we,
  input  logic [DATA_W-1:0]  in_payload,
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [CNT_W-1:0]   cnt_i,
  input  logic               perf_clr,
  output logic               out_valid,
  output logic [WE_W-1:0]    out_we,
  output logic [DATA_W-1:0]  out_payload,
  output logic [ACC_W-1:0]   acc_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [PERF_W-1:0]  bubble_cnt
);

  logic su;
  logic sd;
  logic bubble;

  assign su     = stall[STAGE_IDX];
  assign sd     = stall[STAGE_IDX+1];
  assign bubble = su & ~sd;

  // su=0/sd=1 is not a legal stall pattern; it falls through to ADVANCE below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_we      <= '0;
      out_payload <= NOP_PAYLOAD;
      acc_o       <= '0;
      cnt_o       <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_we      <= '0;
      out_payload <= NOP_PAYLOAD;
      acc_o       <= '0;
      cnt_o       <= '0;
    end else if (bubble) begin
      out_valid   <= 1'b0;
      out_we      <= '0;
      out_payload <= NOP_PAYLOAD;
      acc_o       <= acc_i;
      cnt_o       <= cnt_i;
    end else if (!su) begin
      out_valid   <= in_valid;
      out_we      <= in_valid ? in_we : '0;
      out_payload <= in_payload;
      acc_o       <= '0;
      cnt_o       <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (perf_clr) begin
      bubble_cnt <= '0;
    end else if ((flush || bubble) && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + PERF_W'(1);
    end
  end

`ifndef SYNTHESIS
  illegal_stall_a: assert property (@(posedge clk) disable iff (rst) !(!su && sd))
    else $error("pipe_stage_reg: illegal stall pattern, downstream stalled without upstream");
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: advance, bubble, hold, flush, counter saturation, reset.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_we = '0;
  logic [63:0] in_payload = '0;
  logic [63:0] acc_i = '0;
  logic [1:0]  cnt_i = '0;
  logic        perf_clr = 1'b0;
  logic        out_valid;
  logic [2:0]  out_we;
  logic [63:0] out_payload;
  logic [63:0] acc_o;
  logic [1:0]  cnt_o;
  logic [3:0]  bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg #(
    .DATA_W     (64),
    .WE_W       (3),
    .ACC_W      (64),
    .CNT_W      (2),
    .STALL_W    (6),
    .STAGE_IDX  (3),
    .NOP_PAYLOAD(64'h0),
    .PERF_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_we      (in_we),
    .in_payload (in_payload),
    .acc_i      (acc_i),
    .cnt_i      (cnt_i),
    .perf_clr   (perf_clr),
    .out_valid  (out_valid),
    .out_we     (out_we),
    .out_payload(out_payload),
    .acc_o      (acc_o),
    .cnt_o      (cnt_o),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [2:0] we,
                           input logic [63:0] pl, input logic [63:0] acc, input logic [1:0] cnt,
                           input logic [3:0] bc);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".we"}, 64'(out_we), 64'(we));
    check({tag, ".payload"}, out_payload, pl);
    check({tag, ".acc"}, acc_o, acc);
    check({tag, ".cnt"}, 64'(cnt_o), 64'(cnt));
    check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(bc));
  endtask

  initial begin
    #1 rst = 1'b1;
    step();
    step();
    check_out("reset", 1'b0, 3'b000, 64'h0, 64'h0, 2'd0, 4'd0);
    rst = 1'b0;

    // Advance with valid and invalid instructions
    stall = 6'b000000; in_valid = 1'b1; in_we = 3'b101; in_payload = 64'hDEAD_BEEF;
    acc_i = 64'h77; cnt_i = 2'd3;
    step();
    check_out("adv_valid", 1'b1, 3'b101, 64'hDEAD_BEEF, 64'h0, 2'd0, 4'd0);
    in_valid = 1'b0; in_we = 3'b111; in_payload = 64'h55;
    step();
    check_out("adv_invalid", 1'b0, 3'b000, 64'h55, 64'h0, 2'd0, 4'd0);

    // Bubble captures accumulator progress
    stall = 6'b001111; in_valid = 1'b1; in_we = 3'b111;
    acc_i = 64'h0000_0001_0000_0002; cnt_i = 2'b01;
    step();
    check_out("bubble", 1'b0, 3'b000, 64'h0, 64'h0000_0001_0000_0002, 2'd1, 4'd1);

    stall = 6'b000000; in_valid = 1'b1; in_we = 3'b010; in_payload = 64'hA5;
    step();
    check_out("adv_after_bubble", 1'b1, 3'b010, 64'hA5, 64'h0, 2'd0, 4'd1);

    // Hold with changing inputs
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      in_payload = 64'h1000 + 64'(i); in_we = 3'(i); in_valid = i[0];
      acc_i = 64'hF0 + 64'(i); cnt_i = 2'(i + 1);
      step();
      check_out($sformatf("hold_payload%0d", i), 1'b1, 3'b010, 64'hA5, 64'h0, 2'd0, 4'd1);
    end

    // Hold must also keep captured accumulator state
    stall = 6'b001111; acc_i = 64'h1234; cnt_i = 2'd2;
    step();
    check_out("bubble2", 1'b0, 3'b000, 64'h0, 64'h1234, 2'd2, 4'd2);
    stall = 6'b011111;
    for (int i = 0; i < 2; i++) begin
      acc_i = 64'hBEEF + 64'(i); cnt_i = 2'd3;
      step();
      check_out($sformatf("hold_acc%0d", i), 1'b0, 3'b000, 64'h0, 64'h1234, 2'd2, 4'd2);
    end

    // Flush beats hold and advance
    flush = 1'b1; stall = 6'b011111; acc_i = 64'hFF; in_valid = 1'b1; in_we = 3'b111;
    step();
    check_out("flush_hold", 1'b0, 3'b000, 64'h0, 64'h0, 2'd0, 4'd3);
    stall = 6'b000000; in_payload = 64'h99;
    step();
    check_out("flush_adv", 1'b0, 3'b000, 64'h0, 64'h0, 2'd0, 4'd4);
    flush = 1'b0;

    // Saturation: 4 + 11 reaches 15, then sticks
    stall = 6'b001111; acc_i = 64'h0; cnt_i = 2'd0;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 11 || i == 17)
        check($sformatf("sat_%0d", i), 64'(bubble_cnt), 64'hF);
    end

    // perf_clr wins over increment and leaves pipeline state alone
    perf_clr = 1'b1; acc_i = 64'hABC; cnt_i = 2'd3;
    step();
    check_out("clr_bubble", 1'b0, 3'b000, 64'h0, 64'hABC, 2'd3, 4'd0);
    perf_clr = 1'b0;
    step();
    check("after_clr", 64'(bubble_cnt), 64'd1);
    perf_clr = 1'b1; stall = 6'b000000; in_valid = 1'b1; in_we = 3'b011; in_payload = 64'h77;
    step();
    check_out("clr_adv", 1'b1, 3'b011, 64'h77, 64'h0, 2'd0, 4'd0);
    perf_clr = 1'b0;

    // Asynchronous reset mid-cycle
    in_payload = 64'h1234; in_we = 3'b111; stall = 6'b001111;
    step();
    stall = 6'b000000;
    step();
    check_out("pre_rst", 1'b1, 3'b111, 64'h1234, 64'h0, 2'd0, 4'd1);
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 3'b000, 64'h0, 64'h0, 2'd0, 4'd0);
    rst = 1'b0;
    stall = 6'b001111; acc_i = 64'h99; cnt_i = 2'd2;
    step();
    check("mc_cnt", 64'(cnt_o), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("mc_rst_cnt", 64'(cnt_o), 64'd0);
    check("mc_rst_acc", acc_o, 64'h0);
    step();
    rst = 1'b0; stall = 6'b011111;
    step();
    check("post_rst_cnt", 64'(cnt_o), 64'd0);
    check("post_rst_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the 5-stage CPU. It generalises the EX/MEM latch into a reusable block for IF/ID, ID/EX, EX/MEM and MEM/WB.
- It takes a configurable stall-vector index, a flush input, a payload of configurable width with separate write-enable bits, and multi-cycle accumulator/count feedback (madd/msub/div).
- It adds true hold of all state under a downstream stall and a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 64: payload width in bits (address, data, aluop and similar fields, concatenated by the instantiating stage).
- WE_W, 3: number of write-enable bits that must be forced low on a bubble (for example wreg, whilo, mem_we).
- ACC_W, 64: width of the multi-cycle accumulator feedback (hilo).
- CNT_W, 2: width of the multi-cycle step count.
- STALL_W, 6: width of the global stall vector.
- STAGE_IDX, 3: index of this stage's upstream bit in stall. The downstream bit is STAGE_IDX+1, and STAGE_IDX+1 must be less than STALL_W.
- NOP_PAYLOAD, 0: payload value driven on a bubble.
- PERF_W, 16: width of the bubble counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- stall, input, STALL_W: global stall vector; 1 = Stop.
- flush, input, 1: kill the instruction entering this stage.
- in_valid, input, 1: upstream instruction valid.
- in_we, input, WE_W: upstream write enables.
- in_payload, input, DATA_W: upstream payload.
- acc_i, input, ACC_W: multi-cycle partial result from the execute logic.
- cnt_i, input, CNT_W: multi-cycle step count from the execute logic.
- perf_clr, input, 1: synchronous clear of bubble_cnt.
- out_valid, output, 1: registered valid.
- out_we, output, WE_W: registered write enables.
- out_payload, output, DATA_W: registered payload.
- acc_o, output, ACC_W: accumulator fed back to the execute logic.
- cnt_o, output, CNT_W: step count fed back to the execute logic.
- bubble_cnt, output, PERF_W: saturating count of bubbles inserted.

Behaviour:
- All outputs are registered; latency from in_* to out_* is 1 cycle.
- Let su = stall[STAGE_IDX] and sd = stall[STAGE_IDX+1].
- Reset (rst=1, asynchronous, takes effect immediately):
  - out_valid=0, out_we=0, out_payload=NOP_PAYLOAD.
  - acc_o=0, cnt_o=0, bubble_cnt=0.
  - Reset applied mid multi-cycle operation abandons it; cnt_o=0 on the first edge after release.
- Per-edge update priority when rst=0: FLUSH > BUBBLE > ADVANCE > HOLD.
- FLUSH (flush=1, regardless of stall):
  - out_valid=0, out_we=0, out_payload=NOP_PAYLOAD.
  - acc_o=0, cnt_o=0 (a killed multi-cycle op must not resume).
  - bubble_cnt increments.
- BUBBLE (su=1, sd=0): the upstream stage is stuck, so a NOP goes downstream.
  - out_valid=0, out_we=0, out_payload=NOP_PAYLOAD.
  - acc_o<=acc_i and cnt_o<=cnt_i, which captures multi-cycle progress so the stalled execute op sees its partial result next cycle.
  - bubble_cnt increments.
- ADVANCE (su=0):
  - out_valid<=in_valid, out_we<=in_we when in_valid=1, otherwise 0; out_payload<=in_payload.
  - acc_o=0, cnt_o=0, because the op has completed.
- HOLD (su=1, sd=1): every register keeps its value, including acc_o, cnt_o and the payload. Nothing is cleared.
- Write-enable rule: out_we is all zeros whenever out_valid=0.
- bubble_cnt:
  - Saturates at 2^PERF_W-1 and does not wrap.
  - perf_clr=1 sets it to 0 on the edge and takes precedence over an increment in the same cycle.
  - perf_clr does not affect the pipeline state.
- The case su=0, sd=1 is illegal in the stall protocol and is handled as ADVANCE. Verification flags it with an assertion.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-operation: run ADVANCE with in_payload=64'h1234, then assert rst asynchronously between edges -> outputs go to 0 / NOP_PAYLOAD immediately, before the next clock edge; bubble_cnt=0.
- Advance: STAGE_IDX=3, stall=6'b000000, in_valid=1, in_we=3'b101, in_payload=64'hDEAD_BEEF -> next cycle out_valid=1, out_we=3'b101, out_payload=64'hDEAD_BEEF, acc_o=0, cnt_o=0. Repeat with in_valid=0, in_we=3'b111 -> out_we=0.
- Bubble with accumulator capture: stall=6'b001111, acc_i=64'h0000_0001_0000_0002, cnt_i=2'b01 -> out_valid=0, out_we=0, acc_o=64'h0000_0001_0000_0002, cnt_o=1, bubble_cnt increments by 1. The following cycle, with stall=0 -> acc_o=0, cnt_o=0.
- Hold: load payload 64'hA5, then stall=6'b011111 for 3 cycles while inputs change -> out_* and acc_o/cnt_o are unchanged for all 3 cycles; bubble_cnt is unchanged.
- Flush priority: flush=1 together with stall=6'b011111 and acc_i=64'hFF -> out_valid=0, acc_o=0, cnt_o=0, bubble_cnt+1.
- Counter saturation and clear: PERF_W=4, 17 consecutive BUBBLE cycles -> bubble_cnt stays at 4'hF. Then perf_clr=1 during a BUBBLE cycle -> bubble_cnt=0, out_valid=0.
